// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Transmit end of the single-wire serial link. A parallel word is accepted
// through a valid/ready handshake and sent MSB-first on `so` as a frame:
//   start bit (0), DATA_W data bits, optional parity bit, stop bit (1).
// Every bit is held for BIT_CYC clock cycles. The MSB-first order lets a
// left-shifting receive register fill in natural bit order.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   clear_n     asynchronous active-low reset, released synchronously to clk
//   din         parallel word to send
//   din_valid   din holds a word to send
//   din_ready   block accepts a word this cycle (high only in IDLE)
//   so          serial line out, registered, idles high
//   busy        frame in progress
//   frame_done  one-cycle pulse on the final cycle of the stop bit
//   dbg_state   current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a word transfers on a rising edge where din_valid and din_ready
// are both high. din_ready does not depend on din_valid, and din/din_valid
// are ignored whenever din_ready is low. din may change after that edge.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYC    = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              so,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);
  localparam logic P_ODD     = (PARITY_ODD != 0);
  // With one cycle per bit the first stop cycle is also the last one.
  localparam logic STOP_1CYC = (BIT_CYC == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_so;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  logic                w_bit_end;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_last_stop_nxt;

  assign w_bit_end       = (r_cnt == CNT_MAX);
  assign w_cnt_inc       = r_cnt + CNT_W'(1);
  assign w_shift_nxt     = r_shift << 1;
  // Next cycle is the last cycle of the current bit.
  assign w_last_stop_nxt = (w_cnt_inc == CNT_MAX);

  // All outputs are registered: each branch loads the values for the
  // cycle that follows the edge, so `so` moves one cycle after capture.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_so    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (din_valid && r_ready) begin
            r_shift <= din;
            r_par   <= (^din) ^ P_ODD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_so    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_so    <= r_shift[DATA_W-1];
            r_state <= S_DATA;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= w_shift_nxt;
            if (r_idx == IDX_MAX) begin
              if (PARITY_EN != 0) begin
                r_so    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_so    <= 1'b1;
                r_done  <= STOP_1CYC;
                r_state <= S_STOP;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_so  <= w_shift_nxt[DATA_W-1];
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_so    <= 1'b1;
            r_done  <= STOP_1CYC;
            r_state <= S_STOP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_so    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_done <= w_last_stop_nxt;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_so    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign din_ready  = r_ready;
  assign so         = r_so;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Four transmitters with different configurations run side by side:
//   lane 0: BIT_CYC=1, parity even
//   lane 1: BIT_CYC=1, parity odd
//   lane 2: BIT_CYC=1, no parity
//   lane 3: BIT_CYC=3, parity even
// A reference model turns every accepted word into a queue of expected line
// values (one entry per clock cycle) and a compare process checks all lanes
// on every falling edge. Directed frames are also pinned to literal values.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

  localparam int NL = 4;
  localparam int BC_A [NL] = '{1, 1, 1, 3};
  localparam int PE_A [NL] = '{1, 1, 0, 1};
  localparam int PO_A [NL] = '{0, 1, 0, 0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic clear_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NL-1:0][3:0] din_v;
  logic [NL-1:0]      dv;
  logic [NL-1:0]      rdy_v;
  logic [NL-1:0]      so_v;
  logic [NL-1:0]      busy_v;
  logic [NL-1:0]      done_v;
  logic [NL-1:0][2:0] dbg_v;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    serial_frame_tx #(
      .DATA_W    (4),
      .BIT_CYC   (BC_A[g]),
      .PARITY_EN (PE_A[g]),
      .PARITY_ODD(PO_A[g])
    ) u_dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .din       (din_v[g]),
      .din_valid (dv[g]),
      .din_ready (rdy_v[g]),
      .so        (so_v[g]),
      .busy      (busy_v[g]),
      .frame_done(done_v[g]),
      .dbg_state (dbg_v[g])
    );
  end

  // ---------------- reference model ----------------
  logic       mq [NL][$];
  logic [NL-1:0] exp_so;
  logic [NL-1:0] exp_busy;
  logic [NL-1:0] exp_rdy;
  logic [NL-1:0] exp_done;

  initial begin : model
    logic       fb [$];
    logic [3:0] w;
    forever begin
      @(posedge clk or negedge clear_n);
      for (int l = 0; l < NL; l++) begin
        if (!clear_n) begin
          mq[l].delete();
          exp_so[l]   = 1'b1;
          exp_busy[l] = 1'b0;
          exp_rdy[l]  = 1'b1;
          exp_done[l] = 1'b0;
        end else begin
          if (exp_rdy[l] && dv[l]) begin
            w = din_v[l];
            fb.delete();
            fb.push_back(1'b0);
            for (int b = 3; b >= 0; b--) fb.push_back(w[b]);
            if (PE_A[l] != 0) fb.push_back((^w) ^ (PO_A[l] != 0));
            fb.push_back(1'b1);
            foreach (fb[k])
              for (int r = 0; r < BC_A[l]; r++) mq[l].push_back(fb[k]);
          end
          if (mq[l].size() > 0) begin
            exp_so[l]   = mq[l].pop_front();
            exp_busy[l] = 1'b1;
            exp_rdy[l]  = 1'b0;
            exp_done[l] = (mq[l].size() == 0);
          end else begin
            exp_so[l]   = 1'b1;
            exp_busy[l] = 1'b0;
            exp_rdy[l]  = 1'b1;
            exp_done[l] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int   n_checks;
  int   n_err;
  logic chk_en;

  task automatic check(input string name, input int l,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane %0d at %0t: got %0h expected %0h",
               name, l, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offers one word on lane l, then records n cycles of so/busy/frame_done
  // starting with the first cycle after the capture edge (first cycle = MSB).
  task automatic send_rec(input int l, input logic [3:0] w, input int n,
                          output logic [31:0] so_r, output logic [31:0] busy_r,
                          output logic [31:0] done_r);
    so_r = '0; busy_r = '0; done_r = '0;
    @(negedge clk);
    din_v[l] = w;
    dv[l]    = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) dv[l] = 1'b0;
      so_r   = {so_r[30:0], so_v[l]};
      busy_r = {busy_r[30:0], busy_v[l]};
      done_r = {done_r[30:0], done_v[l]};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] so_r, busy_r, done_r;
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    clear_n  = 1'b0;
    dv       = '0;
    din_v    = '0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int l = 0; l < NL; l++) begin
            check("so",         l, 32'(so_v[l]),   32'(exp_so[l]));
            check("busy",       l, 32'(busy_v[l]), 32'(exp_busy[l]));
            check("din_ready",  l, 32'(rdy_v[l]),  32'(exp_rdy[l]));
            check("frame_done", l, 32'(done_v[l]), 32'(exp_done[l]));
          end
        end
      end
    join_none

    // Reset and idle.
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset state", 0, 32'(dbg_v[0]), 32'd0);
    check("reset so",    0, 32'(so_v),     32'hF);
    clear_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle ready", 0, 32'(rdy_v),  32'hF);
    check("idle busy",  0, 32'(busy_v), 32'h0);

    // Basic frame, even parity.
    send_rec(0, 4'b1011, 8, so_r, busy_r, done_r);
    check("basic so",   0, so_r,   32'h5F);
    check("basic busy", 0, busy_r, 32'hFE);
    check("basic done", 0, done_r, 32'h02);

    // Odd parity, all-zero word.
    send_rec(1, 4'b0000, 8, so_r, busy_r, done_r);
    check("odd so",   1, so_r,   32'h07);
    check("odd done", 1, done_r, 32'h02);

    // No parity bit.
    send_rec(2, 4'b1000, 7, so_r, busy_r, done_r);
    check("nopar so",   2, so_r,   32'h23);
    check("nopar busy", 2, busy_r, 32'h7E);
    check("nopar done", 2, done_r, 32'h02);

    // Bit stretching, 3 cycles per bit.
    send_rec(3, 4'b0110, 22, so_r, busy_r, done_r);
    check("stretch so",   3, so_r,   32'(22'b000_000_111_111_000_000_111_1));
    check("stretch busy", 3, busy_r, 32'h3FFFFE);
    check("stretch done", 3, done_r, 32'h000002);

    // Busy ignore and back-to-back frames on lane 0.
    so_r = '0;
    @(negedge clk);
    din_v[0] = 4'b0011;
    dv[0]    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 2) din_v[0] = 4'b1111;
      if (i == 8) dv[0] = 1'b0;
      so_r = {so_r[30:0], so_v[0]};
    end
    check("b2b so", 0, so_r, 32'h1B7B);

    // Reset during the third data bit of 1010.
    @(negedge clk);
    din_v[0] = 4'b1010;
    dv[0]    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) dv[0] = 1'b0;
    end
    check("pre-reset so", 0, 32'(so_v[0]), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    check("abort so",   0, 32'(so_v[0]),   32'd1);
    check("abort busy", 0, 32'(busy_v[0]), 32'd0);
    check("abort done", 0, 32'(done_v[0]), 32'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    send_rec(0, 4'b0101, 8, so_r, busy_r, done_r);
    check("after reset so",   0, so_r,   32'h2B);
    check("after reset done", 0, done_r, 32'h02);

    // Randomised traffic on all lanes, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1503) clear_n = 1'b1;
      for (int l = 0; l < NL; l++) begin
        dv[l]    = ($urandom_range(0, 3) != 0);
        din_v[l] = 4'($urandom_range(0, 15));
      end
      if (i == 1500) #2 clear_n = 1'b0;
    end
    dv = '0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Transmit end of the team's single-wire serial link. It accepts a parallel word through a valid/ready handshake and serialises it MSB-first onto `so`. Each frame has a start bit, DATA_W data bits, an optional parity bit and a stop bit. The bit order matches the left-shifting serial-in/serial-out registers already used on the receive path, so a receiver shift register fills in natural order. It sits between a word-producing core and the serial pin or the receiver shift chain.

Parameters:
DATA_W, 4, data bits per frame (>=1)
BIT_CYC, 1, clock cycles per serial bit (>=1)
PARITY_EN, 1, 1 = insert parity bit after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, all state changes on rising edge
clear_n  input  1  asynchronous active-low reset
din  input  DATA_W  parallel word to send
din_valid  input  1  din is valid
din_ready  output  1  block can accept a word this cycle
so  output  1  serial line out, registered, idles high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, so=1, din_ready=1, busy=0, frame_done=0, shift register and counters cleared. Release is synchronous to clk.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - so=1, din_ready=1, busy=0.
  - On a rising edge with din_valid&din_ready, capture din into the shift register.
  - Parity is computed from the captured word: XOR of the data bits, XOR PARITY_ODD.
  - Next state is START.
- din_ready is 0 in every state other than IDLE. din and din_valid are ignored while busy. din may change freely after the capture edge.
- Bit timing: a bit counter counts 0..BIT_CYC-1. Each bit holds `so` for exactly BIT_CYC cycles, and the state or bit advances when the counter hits BIT_CYC-1.
- START: so=0 for BIT_CYC cycles, then go to DATA.
- DATA:
  - so = shift_reg[DATA_W-1].
  - At each bit boundary, shift left by one (zero fill) and increment the data index.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: so = parity bit for BIT_CYC cycles, then go to STOP.
- STOP: so=1 for BIT_CYC cycles. frame_done=1 during the last stop cycle only. Next state is IDLE.
- busy=1 in START, DATA, PARITY and STOP.
- Frame length is (2+DATA_W+PARITY_EN)*BIT_CYC cycles, and `so` changes one cycle after the capture edge.
- Back-to-back frames: ready returns in the IDLE cycle after STOP. The minimum gap between frames is therefore 1 idle cycle at so=1 beyond the stop bit, and the line is never low between frames.
- `so` is driven straight from a flop, with no combinational path from din or din_valid.
- Reset mid-frame: the frame is aborted immediately, so=1, and no frame_done pulse. The next frame starts cleanly after release.
- din_valid held high continuously: a new word is captured on each IDLE cycle, giving one frame per (frame length + 1) cycles.

Test Plan:
- Reset/idle: DATA_W=4, BIT_CYC=1, PARITY_EN=1, even parity; hold clear_n low, then release with din_valid=0 for 10 cycles -> so=1, din_ready=1, busy=0, frame_done=0 throughout.
- Basic frame (same config): send din=4'b1011 -> so per cycle after capture = 0,1,0,1,1,1(parity),1(stop), then idle 1. busy high for 7 cycles, frame_done high on the 7th.
- Odd parity, no stretch (PARITY_ODD=1): send din=4'b0000 -> so = 0,0,0,0,0,1,1. Then set PARITY_EN=0 and send din=4'b1000 -> so = 0,1,0,0,0,1 (6 cycles).
- Bit stretching (BIT_CYC=3): send din=4'b0110 -> every bit lasts exactly 3 cycles, 21 cycles total. frame_done is a single pulse in cycle 21.
- Busy ignore and back-to-back:
  - Hold din_valid=1 and change din to 4'b1111 mid-frame -> the first frame is unaffected.
  - The second frame starts exactly 1 idle cycle after the first stop bit and carries 4'b1111.
- Reset mid-frame: assert clear_n low during the 3rd data bit of 4'b1010 -> so=1 immediately (asynchronous), busy=0, no frame_done. The next accepted word 4'b0101 transmits correctly.
